// File: rtl/maxpool_relu2.sv
// ReLU followed by 2x2 stride-2 max pooling on three 12-bit signed channel streams.
// Optional frame_done output is enabled with `define MAXPOOL2_FRAME_DONE_EN.
module maxpool_relu2 #(
    parameter int CONV_BIT = 12,
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [CONV_BIT-1:0] conv_out_1,
    input  logic [CONV_BIT-1:0] conv_out_2,
    input  logic [CONV_BIT-1:0] conv_out_3,
    output logic [CONV_BIT-1:0] max_value_1,
    output logic [CONV_BIT-1:0] max_value_2,
    output logic [CONV_BIT-1:0] max_value_3,
    output logic                valid_out_relu2
`ifdef MAXPOOL2_FRAME_DONE_EN
    ,
    output logic                frame_done
`endif
);
    // Handshake: valid_in qualifies one pixel (all channels) per cycle; there is no
    // ready, so the consumer must take every single-cycle valid_out_relu2 strobe.
    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(HEIGHT);
    localparam int HALFW = WIDTH / 2;

    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [CONV_BIT-1:0] pair_reg [3];
    logic [CONV_BIT-1:0] line_buf [3][HALFW];
    logic [CONV_BIT-1:0] max_q    [3];

    logic [CONV_BIT-1:0] pix      [3];
    logic [CONV_BIT-1:0] r        [3];
    logic [CONV_BIT-1:0] pm       [3];
    logic [CONV_BIT-1:0] win      [3];
    logic [CW-2:0]       buf_idx;

    logic col_last;
    logic row_last;

    assign col_last = (col == CW'(WIDTH - 1));
    assign row_last = (row == RW'(HEIGHT - 1));
    assign buf_idx  = col[CW-1:1];

    assign pix[0] = conv_out_1;
    assign pix[1] = conv_out_2;
    assign pix[2] = conv_out_3;

    // After ReLU everything is non-negative, so plain unsigned compares suffice.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            r[ch]   = pix[ch][CONV_BIT-1] ? '0 : pix[ch];
            pm[ch]  = (pair_reg[ch] > r[ch]) ? pair_reg[ch] : r[ch];
            win[ch] = (line_buf[ch][buf_idx] > pm[ch]) ? line_buf[ch][buf_idx] : pm[ch];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col             <= '0;
            row             <= '0;
            valid_out_relu2 <= 1'b0;
`ifdef MAXPOOL2_FRAME_DONE_EN
            frame_done      <= 1'b0;
`endif
            for (int ch = 0; ch < 3; ch++) begin
                pair_reg[ch] <= '0;
                max_q[ch]    <= '0;
                for (int i = 0; i < HALFW; i++) begin
                    line_buf[ch][i] <= '0;
                end
            end
        end else begin
            valid_out_relu2 <= 1'b0;
`ifdef MAXPOOL2_FRAME_DONE_EN
            frame_done      <= 1'b0;
`endif
            if (valid_in) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                for (int ch = 0; ch < 3; ch++) begin
                    if (!col[0]) begin
                        pair_reg[ch] <= r[ch];
                    end else if (!row[0]) begin
                        line_buf[ch][buf_idx] <= pm[ch];
                    end else begin
                        max_q[ch] <= win[ch];
                    end
                end

                // Bottom-right pixel of a 2x2 window completes one pooled result.
                valid_out_relu2 <= col[0] & row[0];
`ifdef MAXPOOL2_FRAME_DONE_EN
                frame_done      <= col_last & row_last;
`endif
            end
        end
    end

    assign max_value_1 = max_q[0];
    assign max_value_2 = max_q[1];
    assign max_value_3 = max_q[2];

endmodule

// File: tb/tb_maxpool_relu2.sv
// Self-checking bench for maxpool_relu2; frame_done checks build only with MAXPOOL2_FRAME_DONE_EN.
module tb_maxpool_relu2;
    localparam int CB = 12;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NP = W * H;
    localparam int NO = (W / 2) * (H / 2);
    localparam int OW = 3 * CB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [CB-1:0] c1, c2, c3;
    logic [CB-1:0] m1, m2, m3;
    logic          vo;
`ifdef MAXPOOL2_FRAME_DONE_EN
    logic          fd;
`endif

    logic [CB-1:0] img [3][NP];
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] obs_q[$];
    int            fd_idx_q[$];
    int            timing_errs;
    int            tests_run;
    int            tests_failed;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    maxpool_relu2 #(.CONV_BIT(CB), .WIDTH(W), .HEIGHT(H)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .conv_out_1      (c1),
        .conv_out_2      (c2),
        .conv_out_3      (c3),
        .max_value_1     (m1),
        .max_value_2     (m2),
        .max_value_3     (m3),
        .valid_out_relu2 (vo)
`ifdef MAXPOOL2_FRAME_DONE_EN
        ,
        .frame_done      (fd)
`endif
    );

    // ---------------- driver ----------------
    // Sends pixels 0..npix-1 of img, one per strobe, with gap idle cycles after each.
    // Outputs are sampled on the falling edge right after the consuming rising edge.
    task automatic drive_image(input int npix, input int min_gap, input int max_gap);
        int  gap;
        logic strobe_exp;
        for (int p = 0; p < npix; p++) begin
            c1 = img[0][p];
            c2 = img[1][p];
            c3 = img[2][p];
            valid_in = 1'b1;
            @(negedge clk);
            strobe_exp = (((p / W) % 2) == 1) && (((p % W) % 2) == 1);
            if (vo === 1'b1) obs_q.push_back({m1, m2, m3});
            if (vo !== strobe_exp) timing_errs++;
`ifdef MAXPOOL2_FRAME_DONE_EN
            if (fd === 1'b1) begin
                if (vo !== 1'b1) timing_errs++;
                fd_idx_q.push_back(obs_q.size() - 1);
            end
`endif
            valid_in = 1'b0;
            gap = $urandom_range(max_gap, min_gap);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (vo !== 1'b0) timing_errs++;
`ifdef MAXPOOL2_FRAME_DONE_EN
                if (fd !== 1'b0) timing_errs++;
`endif
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        fd_idx_q.delete();
        timing_errs = 0;
    endtask

    // ---------------- reference model ----------------
    // Pooled value = largest ReLU'd sample of each non-overlapping 2x2 block, raster order.
    task automatic model_image();
        logic [OW-1:0] e;
        int best, v;
        logic [CB-1:0] s;
        for (int pr = 0; pr < H / 2; pr++) begin
            for (int pc = 0; pc < W / 2; pc++) begin
                e = '0;
                for (int ch = 0; ch < 3; ch++) begin
                    best = 0;
                    for (int dy = 0; dy < 2; dy++) begin
                        for (int dx = 0; dx < 2; dx++) begin
                            s = img[ch][(2 * pr + dy) * W + 2 * pc + dx];
                            v = s[CB-1] ? 0 : int'(s);
                            if (v > best) best = v;
                        end
                    end
                    e[(2 - ch) * CB +: CB] = best[CB-1:0];
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_ramp(input int offset);
        for (int p = 0; p < NP; p++) begin
            img[0][p] = CB'(p + offset);
            img[1][p] = CB'($urandom_range(4095, 0));
            img[2][p] = CB'($urandom_range(4095, 0));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests_run++;
        if ({vo, m1, m2, m3} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got vo=%0b m=%0d/%0d/%0d, want all 0", vo, m1, m2, m3);
        end
`ifdef MAXPOOL2_FRAME_DONE_EN
        tests_run++;
        if (fd !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_frame_done: got %0b, want 0", fd);
        end
`endif
    endtask

    task automatic test_ramp();
        int want;
        clear_obs();
        fill_ramp(0);
        model_image();
        drive_image(NP, 0, 0);
        tests_run++;
        if (obs_q.size() !== NO) begin
            tests_failed++;
            $display("FAIL ramp_count: got %0d strobes, want %0d", obs_q.size(), NO);
        end
        for (int i = 0; i < NO; i++) begin
            want = (2 * (i / 4) + 1) * W + 2 * (i % 4) + 1;
            tests_run++;
            if (obs_q[i] !== exp_q[i] || obs_q[i][OW-1 -: CB] !== CB'(want)) begin
                tests_failed++;
                $display("FAIL ramp_out[%0d]: got %h, want %h (ch1 %0d)", i, obs_q[i], exp_q[i], want);
            end
        end
        tests_run++;
        if (timing_errs !== 0) begin
            tests_failed++;
            $display("FAIL ramp_timing: got %0d misplaced strobes, want 0", timing_errs);
        end
    endtask

    task automatic test_relu();
        clear_obs();
        fill_ramp(0);
        for (int p = 0; p < NP; p++) img[1][p] = 12'hF00;
        img[1][1 * W + 1] = 12'h005;
        model_image();
        drive_image(NP, 0, 1);
        tests_run++;
        if (obs_q.size() !== NO) begin
            tests_failed++;
            $display("FAIL relu_count: got %0d strobes, want %0d", obs_q.size(), NO);
        end
        for (int i = 0; i < NO; i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i] || obs_q[i][CB +: CB] !== ((i == 0) ? 12'd5 : 12'd0)) begin
                tests_failed++;
                $display("FAIL relu_out[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (timing_errs !== 0) begin
            tests_failed++;
            $display("FAIL relu_timing: got %0d misplaced strobes, want 0", timing_errs);
        end
    endtask

    task automatic test_gapped();
        clear_obs();
        fill_ramp(0);
        model_image();
        drive_image(NP, 2, 2);
        tests_run++;
        if (obs_q.size() !== NO) begin
            tests_failed++;
            $display("FAIL gapped_count: got %0d strobes, want %0d", obs_q.size(), NO);
        end
        for (int i = 0; i < NO; i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL gapped_out[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (timing_errs !== 0) begin
            tests_failed++;
            $display("FAIL gapped_timing: got %0d misplaced strobes, want 0", timing_errs);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        fill_ramp(0);
        model_image();
        drive_image(NP, 0, 0);
        fill_ramp(100);
        model_image();
        drive_image(NP, 0, 0);
        tests_run++;
        if (obs_q.size() !== 2 * NO) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d strobes, want %0d", obs_q.size(), 2 * NO);
        end
        for (int i = 0; i < 2 * NO; i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b_out[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (obs_q[2 * NO - 1][OW-1 -: CB] !== 12'd163 || obs_q[NO][OW-1 -: CB] !== 12'd109) begin
            tests_failed++;
            $display("FAIL b2b_edges: got %0d..%0d, want 109..163",
                     obs_q[NO][OW-1 -: CB], obs_q[2 * NO - 1][OW-1 -: CB]);
        end
        tests_run++;
        if (timing_errs !== 0) begin
            tests_failed++;
            $display("FAIL b2b_timing: got %0d misplaced strobes, want 0", timing_errs);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        fill_ramp(0);
        drive_image(20, 0, 0);
        valid_in = 1'b1;
        rst_n    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests_run++;
            if ({vo, m1, m2, m3} !== '0) begin
                tests_failed++;
                $display("FAIL midreset_hold[%0d]: got vo=%0b m=%0d/%0d/%0d, want all 0", k, vo, m1, m2, m3);
            end
        end
        valid_in = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        clear_obs();
        fill_ramp(0);
        model_image();
        drive_image(NP, 0, 0);
        tests_run++;
        if (obs_q.size() !== NO) begin
            tests_failed++;
            $display("FAIL midreset_count: got %0d strobes, want %0d", obs_q.size(), NO);
        end
        for (int i = 0; i < NO; i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL midreset_out[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (timing_errs !== 0) begin
            tests_failed++;
            $display("FAIL midreset_timing: got %0d misplaced strobes, want 0", timing_errs);
        end
    endtask

    task automatic test_random();
        clear_obs();
        for (int img_n = 0; img_n < 3; img_n++) begin
            for (int ch = 0; ch < 3; ch++)
                for (int p = 0; p < NP; p++) img[ch][p] = CB'($urandom_range(4095, 0));
            model_image();
            drive_image(NP, 0, 3);
        end
        tests_run++;
        if (obs_q.size() !== 3 * NO) begin
            tests_failed++;
            $display("FAIL random_count: got %0d strobes, want %0d", obs_q.size(), 3 * NO);
        end
        for (int i = 0; i < 3 * NO; i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL random_out[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (timing_errs !== 0) begin
            tests_failed++;
            $display("FAIL random_timing: got %0d misplaced strobes, want 0", timing_errs);
        end
    endtask

`ifdef MAXPOOL2_FRAME_DONE_EN
    task automatic test_frame_done();
        clear_obs();
        fill_ramp(0);
        drive_image(NP, 0, 2);
        tests_run++;
        if (fd_idx_q.size() !== 1) begin
            tests_failed++;
            $display("FAIL frame_done_count: got %0d pulses, want 1", fd_idx_q.size());
        end
        tests_run++;
        if (fd_idx_q.size() > 0 && fd_idx_q[0] !== NO - 1) begin
            tests_failed++;
            $display("FAIL frame_done_pos: got strobe %0d, want %0d", fd_idx_q[0], NO - 1);
        end
        tests_run++;
        if (timing_errs !== 0) begin
            tests_failed++;
            $display("FAIL frame_done_timing: got %0d misplaced pulses, want 0", timing_errs);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        timing_errs  = 0;
        rst_n        = 1'b0;
        valid_in     = 1'b0;
        c1 = '0;
        c2 = '0;
        c3 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_ramp();
        test_relu();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MAXPOOL2_FRAME_DONE_EN
        test_frame_done();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
